alu_issue: RTL
==============

// Module: alu_issue
// PURPOSE
//  Producer side of the ALU control interface: decodes RV32I OP / OP-IMM / LUI instructions into the
//  4-bit ALU control code plus operand pair, and registers them for the execute stage.
//  Sits between decode/regfile read and the ALU; valid/ready handshake on both sides with a skid entry.
//  Output registers drive the ALU control and operand inputs directly.
// PARAMETERS
//  XLEN     32  datapath width; only 32 is supported.
//  SKID_EN  1   1: registered upstream ready via a 1-entry skid buffer; 0: o_ready = i_ready | ~o_valid
// PORTS
//  i_clk       in   1     clock, all state on rising edge
//  i_rst       in   1     synchronous reset, active-high
//  i_flush     in   1     synchronous pipeline flush, discards all held entries
//  i_valid     in   1     upstream instruction + operands valid
//  o_ready     out  1     block can accept this cycle
//  i_instr     in   32    instruction word
//  i_rs1       in   XLEN  rs1 register value
//  i_rs2       in   XLEN  rs2 register value
//  o_valid     out  1     issued entry valid
//  i_ready     in   1     execute stage accepts the entry
//  o_control   out  4     ALU code: ADD=0 SLL=1 SLT=2 SLTU=3 XOR=4 SRL=5 OR=6 AND=7 SUB=8 SRA=d
//  o_op1       out  XLEN  ALU operand 1
//  o_op2       out  XLEN  ALU operand 2
//  o_rd        out  5     destination register (instr[11:7])
//  o_illegal   out  1     entry is an undecodable instruction
// BEHAVIOUR
//  Reset (i_rst=1 at edge): o_valid=0, skid empty, o_control=0, o_op1=0, o_op2=0, o_rd=0, o_illegal=0.
//   o_ready=1 from the first cycle after reset. Reset wins over flush and all handshakes.
//  Transfer in: i_valid & o_ready at edge. Transfer out: o_valid & i_ready at edge.
//  Latency: accepted input appears on outputs the next cycle when output register is empty/draining.
//  Decode (opcode=instr[6:0], f3=instr[14:12], f7=instr[31:25]):
//   0110011 OP: control={f7[5],f3}; op1=rs1, op2=rs2. Legal iff f7==0, or f7==7'h20 with f3 in {000,101}.
//   0010011 OP-IMM: f3!=001/101: control={0,f3}, op2=sext(instr[31:20]).
//    f3=001: legal iff f7==0; f3=101: legal iff f7 in {0,7'h20}; control={f7[5],f3}, op2={27'b0,instr[24:20]}.
//    op1=rs1.
//   0110111 LUI: control=ADD, op1=0, op2={instr[31:12],12'b0}.
//   Any other opcode or illegal funct: o_illegal=1, control=ADD, op1=op2=0; rd still passed through.
//  SKID_EN=1: o_ready = ~skid_valid (pure register output).
//   Input accepted while output held (o_valid & ~i_ready) -> stored in skid.
//   When output drains, skid entry moves to output before any new input; order strictly preserved.
//   Accept and drain in the same cycle with skid empty -> new entry replaces output, o_valid stays 1.
//  SKID_EN=0: no skid; output register loads whenever o_ready.
//  Output entry stable (all o_* fields) while o_valid & ~i_ready; no field changes until transfer.
//  Flush: at edge with i_flush=1, o_valid=0 and skid emptied; a simultaneous input transfer is dropped.
//   Data fields need not clear on flush. o_ready=1 the cycle after flush.
//  Back-to-back: sustains 1 instr/cycle while i_ready=1.
// STRUCTURE
//  Shared package alu_pkg: ALU control code localparams (ADD..SRA as above), RV32I opcode constants
//   (OPC_OP, OPC_OPIMM, OPC_LUI); the ALU uses the same codes.
//  Sub-module alu_dec: combinational instr/rs1/rs2 -> {control, op1, op2, rd, illegal}.
//   Used once at the input; alu_issue holds the output register, skid register and handshake.
// TESTING
//  1. Reset then idle: o_valid=0, o_ready=1, o_control=0, o_op1=o_op2=0.
//  2. ADD/SUB x3,x1,x2 (rs1=5, rs2=3), f7=0 then 0x20 -> control 0 then 8; op1=5, op2=3; rd=3;
//     each 1 cycle after accept.
//  3. ADDI rs1=10, imm=0xFFF -> control 0, op2=0xFFFFFFFF; SRAI shamt=4 (f7=0x20) -> control d, op2=4;
//     SLLI with f7=0x20 -> o_illegal=1.
//  4. LUI imm=0x12345 -> op1=0, op2=0x12345000, control 0; opcode 0x03 -> o_illegal=1, control 0.
//  5. Backpressure (SKID_EN=1): i_ready=0, send A,B -> o_valid=1 holding A, o_ready=0 after B;
//     i_ready=1 -> A then B in order, no loss.
//  6. Flush with A on output, B in skid and C presented -> next cycle o_valid=0, o_ready=1; A, B, C never issued.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU control codes, RV32I opcodes and the issued-entry record.
// The execute-stage ALU decodes the same control codes.
package alu_pkg;

    localparam int DATA_W = 32;

    localparam logic [3:0] ALU_ADD  = 4'h0;
    localparam logic [3:0] ALU_SLL  = 4'h1;
    localparam logic [3:0] ALU_SLT  = 4'h2;
    localparam logic [3:0] ALU_SLTU = 4'h3;
    localparam logic [3:0] ALU_XOR  = 4'h4;
    localparam logic [3:0] ALU_SRL  = 4'h5;
    localparam logic [3:0] ALU_OR   = 4'h6;
    localparam logic [3:0] ALU_AND  = 4'h7;
    localparam logic [3:0] ALU_SUB  = 4'h8;
    localparam logic [3:0] ALU_SRA  = 4'hd;

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;

    typedef struct packed {
        logic [3:0]        control;
        logic [DATA_W-1:0] op1;
        logic [DATA_W-1:0] op2;
        logic [4:0]        rd;
        logic              illegal;
    } alu_entry_t;

endpackage

// File: rtl/alu_dec.sv
// Combinational RV32I OP / OP-IMM / LUI decoder producing one ALU entry.
// Undecodable words become an ADD of zeros flagged illegal, rd still passed through.
module alu_dec
    import alu_pkg::*;
(
    input  logic [31:0]       instr,
    input  logic [DATA_W-1:0] rs1,
    input  logic [DATA_W-1:0] rs2,
    output alu_entry_t        entry
);

    logic [6:0]        opc;
    logic [2:0]        f3;
    logic [6:0]        f7;
    logic              legal;
    logic [3:0]        ctl;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;

    assign opc = instr[6:0];
    assign f3  = instr[14:12];
    assign f7  = instr[31:25];

    always_comb begin
        legal = 1'b0;
        ctl   = ALU_ADD;
        a     = '0;
        b     = '0;
        case (opc)
            OPC_OP: begin
                legal = (f7 == 7'h00) ||
                        (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101));
                ctl   = {f7[5], f3};
                a     = rs1;
                b     = rs2;
            end
            OPC_OPIMM: begin
                a = rs1;
                case (f3)
                    3'b001, 3'b101: begin
                        // shifts: f7 selects SRL/SRA, low immediate bits are the shamt
                        legal = (f7 == 7'h00) || (f3 == 3'b101 && f7 == 7'h20);
                        ctl   = {f7[5], f3};
                        b     = {27'b0, instr[24:20]};
                    end
                    default: begin
                        legal = 1'b1;
                        ctl   = {1'b0, f3};
                        b     = {{20{instr[31]}}, instr[31:20]};
                    end
                endcase
            end
            OPC_LUI: begin
                legal = 1'b1;
                ctl   = ALU_ADD;
                b     = {instr[31:12], 12'b0};
            end
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        entry.control = legal ? ctl : ALU_ADD;
        entry.op1     = legal ? a : '0;
        entry.op2     = legal ? b : '0;
        entry.rd      = instr[11:7];
        entry.illegal = ~legal;
    end

endmodule

// File: rtl/alu_issue.sv
// ALU issue stage: decodes at the input and registers the entry for execute,
// with an optional one-entry skid so upstream ready is a pure register output.
module alu_issue
    import alu_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter bit SKID_EN = 1'b1
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_flush,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [31:0]     i_instr,
    input  logic [XLEN-1:0] i_rs1,
    input  logic [XLEN-1:0] i_rs2,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [3:0]      o_control,
    output logic [XLEN-1:0] o_op1,
    output logic [XLEN-1:0] o_op2,
    output logic [4:0]      o_rd,
    output logic            o_illegal
);

    alu_entry_t dec_entry;
    alu_entry_t out_entry;
    alu_entry_t skid_entry;
    logic       out_valid;
    logic       skid_valid;
    logic       in_fire;
    logic       out_load;

    alu_dec u_dec (
        .instr (i_instr),
        .rs1   (i_rs1),
        .rs2   (i_rs2),
        .entry (dec_entry)
    );

    assign o_ready  = SKID_EN ? ~skid_valid : (i_ready | ~out_valid);
    assign in_fire  = i_valid & o_ready;
    // output register may take a new entry when empty or draining this edge
    assign out_load = ~out_valid | i_ready;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
            out_entry  <= '0;
            skid_entry <= '0;
        end else if (i_flush) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
        end else if (out_load) begin
            if (skid_valid) begin
                out_entry  <= skid_entry;
                out_valid  <= 1'b1;
                skid_valid <= 1'b0;
            end else if (in_fire) begin
                out_entry <= dec_entry;
                out_valid <= 1'b1;
            end else begin
                out_valid <= 1'b0;
            end
        end else if (SKID_EN && in_fire) begin
            skid_entry <= dec_entry;
            skid_valid <= 1'b1;
        end
    end

    assign o_valid   = out_valid;
    assign o_control = out_entry.control;
    assign o_op1     = out_entry.op1;
    assign o_op2     = out_entry.op2;
    assign o_rd      = out_entry.rd;
    assign o_illegal = out_entry.illegal;

endmodule
